// File: rtl/mmcm_drp_pkg.sv
// Shared types and constants for the MMCME2 DRP reconfiguration sequencer.
package mmcm_drp_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CHECK,
        ST_RST_ON,
        ST_RD,
        ST_RD_WAIT,
        ST_WR,
        ST_WR_WAIT,
        ST_VFY,
        ST_VFY_WAIT,
        ST_RELEASE,
        ST_LOCK_WAIT,
        ST_FIN
    } state_t;

    // Layout of the register currently being rewritten.
    typedef enum logic [1:0] {
        K_REG1,
        K_REG2,
        K_DIVCLK
    } reg_kind_t;

    localparam logic [6:0] ADDR_CLKFB_REG1 = 7'h14;
    localparam logic [6:0] ADDR_CLKFB_REG2 = 7'h15;
    localparam logic [6:0] ADDR_DIVCLK     = 7'h16;

    // Bits of the old register contents that survive the rewrite.
    localparam logic [15:0] KEEP_REG1   = 16'h1000;
    localparam logic [15:0] KEEP_REG2   = 16'hFF00;
    localparam logic [15:0] KEEP_DIVCLK = 16'hC000;

    localparam logic [2:0] ERR_OK       = 3'd0;
    localparam logic [2:0] ERR_CFG      = 3'd1;
    localparam logic [2:0] ERR_DRDY     = 3'd2;
    localparam logic [2:0] ERR_LOCK     = 3'd3;
    localparam logic [2:0] ERR_READBACK = 3'd4;

    localparam logic [6:0] DIV_MIN = 7'd1;
    localparam logic [6:0] DIV_MAX = 7'd126;

    // REG1 address of CLKOUTn; REG2 is always the next address.
    function automatic logic [6:0] clkout_reg1_addr(input int n);
        case (n)
            0:       return 7'h08;
            1:       return 7'h0A;
            2:       return 7'h0C;
            3:       return 7'h0E;
            4:       return 7'h10;
            5:       return 7'h06;
            6:       return 7'h12;
            default: return 7'h08;
        endcase
    endfunction

endpackage

// File: rtl/mmcm_div_encode.sv
// Integer divide value to MMCM counter fields (high/low time, edge, no_count).
module mmcm_div_encode (
    input  logic [6:0] d,
    output logic [5:0] high,
    output logic [5:0] low,
    output logic       edge_bit,
    output logic       no_count
);

    // Divide-by-1 bypasses the counter; otherwise split d into high and low halves.
    always_comb begin
        if (d == 7'd1) begin
            high     = 6'd1;
            low      = 6'd1;
            edge_bit = 1'b0;
            no_count = 1'b1;
        end else begin
            high     = d[6:1];
            low      = 6'(d - {1'b0, d[6:1]});
            edge_bit = d[0];
            no_count = 1'b0;
        end
    end

endmodule

// File: rtl/mmcm_drp_seq.sv
// MMCME2 DRP reconfiguration sequencer: validates divides, read-modify-writes
// every counter register with the MMCM in reset, then waits for lock.
// Optional build macro MMCM_DRP_READBACK_EN adds a verify read after each write.
module mmcm_drp_seq
    import mmcm_drp_pkg::*;
#(
    parameter int NUM_CLKOUT   = 2,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [7*NUM_CLKOUT-1:0] clkout_div,
    input  logic [6:0]              fb_mult,
    input  logic [6:0]              divclk_div,
    output logic                    busy,
    output logic                    done,
    output logic [2:0]              err_code,
    output logic [6:0]              daddr,
    output logic [15:0]             di,
    input  logic [15:0]             do_in,
    output logic                    den,
    output logic                    dwe,
    input  logic                    drdy,
    output logic                    mmcm_rst,
    input  logic                    locked
);

    localparam int NREG = 2 * NUM_CLKOUT + 3;
    localparam int IW   = $clog2(NREG);
    localparam int TMAX = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    state_t          state_reg;
    logic [6:0]      div_reg [NUM_CLKOUT];
    logic [6:0]      fb_reg;
    logic [6:0]      dc_reg;
    logic [IW-1:0]   idx_reg;
    logic [15:0]     old_reg;
    logic [TW-1:0]   timer_reg;

    logic [NUM_CLKOUT+1:0] div_ok;
    logic [6:0]      cur_div;
    logic [6:0]      cur_addr;
    reg_kind_t       cur_kind;
    logic [5:0]      enc_high;
    logic [5:0]      enc_low;
    logic            enc_edge;
    logic            enc_nc;
    logic [15:0]     wr_data;
    logic            last_reg;
    logic            drp_expired;
    logic            lock_expired;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLKOUT; gi++) begin : g_chk
            assign div_ok[gi] = (div_reg[gi] >= DIV_MIN) && (div_reg[gi] <= DIV_MAX);
        end
    endgenerate
    assign div_ok[NUM_CLKOUT]   = (fb_reg >= DIV_MIN) && (fb_reg <= DIV_MAX);
    assign div_ok[NUM_CLKOUT+1] = (dc_reg >= DIV_MIN) && (dc_reg <= DIV_MAX);

    assign last_reg     = (idx_reg == IW'(NREG - 1));
    assign drp_expired  = (timer_reg == TW'(DRDY_TIMEOUT - 1));
    assign lock_expired = (timer_reg == TW'(LOCK_TIMEOUT - 1));

    // Map the register-list index to its divide value, address and field layout.
    always_comb begin
        cur_div  = dc_reg;
        cur_addr = ADDR_DIVCLK;
        cur_kind = K_DIVCLK;
        if (idx_reg == IW'(NREG - 3)) begin
            cur_div  = fb_reg;
            cur_addr = ADDR_CLKFB_REG1;
            cur_kind = K_REG1;
        end else if (idx_reg == IW'(NREG - 2)) begin
            cur_div  = fb_reg;
            cur_addr = ADDR_CLKFB_REG2;
            cur_kind = K_REG2;
        end
        for (int n = 0; n < NUM_CLKOUT; n++) begin
            if (idx_reg == IW'(2 * n)) begin
                cur_div  = div_reg[n];
                cur_addr = clkout_reg1_addr(n);
                cur_kind = K_REG1;
            end else if (idx_reg == IW'(2 * n + 1)) begin
                cur_div  = div_reg[n];
                cur_addr = clkout_reg1_addr(n) | 7'h01;
                cur_kind = K_REG2;
            end
        end
    end

    mmcm_div_encode u_enc (
        .d        (cur_div),
        .high     (enc_high),
        .low      (enc_low),
        .edge_bit (enc_edge),
        .no_count (enc_nc)
    );

    // Merge the new counter fields into the preserved bits of the value just read.
    always_comb begin
        case (cur_kind)
            K_REG1:  wr_data = (old_reg & KEEP_REG1) | {4'b0, enc_high, enc_low};
            K_REG2:  wr_data = (old_reg & KEEP_REG2) | {8'b0, enc_edge, enc_nc, 6'b0};
            default: wr_data = (old_reg & KEEP_DIVCLK) | {2'b0, enc_edge, enc_nc, enc_high, enc_low};
        endcase
    end

    // Sequencer FSM with all DRP and handshake outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_code  <= ERR_OK;
            daddr     <= 7'd0;
            di        <= 16'd0;
            den       <= 1'b0;
            dwe       <= 1'b0;
            mmcm_rst  <= 1'b0;
            idx_reg   <= '0;
            old_reg   <= 16'd0;
            timer_reg <= '0;
            fb_reg    <= 7'd0;
            dc_reg    <= 7'd0;
            for (int n = 0; n < NUM_CLKOUT; n++) div_reg[n] <= 7'd0;
        end else begin
            done <= 1'b0;
            den  <= 1'b0;
            dwe  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start && !busy) begin
                        for (int n = 0; n < NUM_CLKOUT; n++) div_reg[n] <= clkout_div[7*n +: 7];
                        fb_reg    <= fb_mult;
                        dc_reg    <= divclk_div;
                        err_code  <= ERR_OK;
                        busy      <= 1'b1;
                        idx_reg   <= '0;
                        state_reg <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (&div_ok) begin
                        state_reg <= ST_RST_ON;
                    end else begin
                        err_code  <= ERR_CFG;
                        state_reg <= ST_FIN;
                    end
                end
                ST_RST_ON: begin
                    mmcm_rst  <= 1'b1;
                    state_reg <= ST_RD;
                end
                ST_RD: begin
                    den       <= 1'b1;
                    daddr     <= cur_addr;
                    timer_reg <= '0;
                    state_reg <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (drdy) begin
                        old_reg   <= do_in;
                        state_reg <= ST_WR;
                    end else if (drp_expired) begin
                        err_code  <= ERR_DRDY;
                        mmcm_rst  <= 1'b0;
                        state_reg <= ST_FIN;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                ST_WR: begin
                    den       <= 1'b1;
                    dwe       <= 1'b1;
                    di        <= wr_data;
                    timer_reg <= '0;
                    state_reg <= ST_WR_WAIT;
                end
                ST_WR_WAIT: begin
                    if (drdy) begin
`ifdef MMCM_DRP_READBACK_EN
                        state_reg <= ST_VFY;
`else
                        if (last_reg) begin
                            state_reg <= ST_RELEASE;
                        end else begin
                            idx_reg   <= idx_reg + 1'b1;
                            state_reg <= ST_RD;
                        end
`endif
                    end else if (drp_expired) begin
                        err_code  <= ERR_DRDY;
                        mmcm_rst  <= 1'b0;
                        state_reg <= ST_FIN;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
`ifdef MMCM_DRP_READBACK_EN
                ST_VFY: begin
                    den       <= 1'b1;
                    timer_reg <= '0;
                    state_reg <= ST_VFY_WAIT;
                end
                ST_VFY_WAIT: begin
                    if (drdy) begin
                        if (do_in != di) begin
                            err_code  <= ERR_READBACK;
                            mmcm_rst  <= 1'b0;
                            state_reg <= ST_FIN;
                        end else if (last_reg) begin
                            state_reg <= ST_RELEASE;
                        end else begin
                            idx_reg   <= idx_reg + 1'b1;
                            state_reg <= ST_RD;
                        end
                    end else if (drp_expired) begin
                        err_code  <= ERR_DRDY;
                        mmcm_rst  <= 1'b0;
                        state_reg <= ST_FIN;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
`endif
                ST_RELEASE: begin
                    mmcm_rst  <= 1'b0;
                    timer_reg <= '0;
                    state_reg <= ST_LOCK_WAIT;
                end
                ST_LOCK_WAIT: begin
                    if (locked) begin
                        state_reg <= ST_FIN;
                    end else if (lock_expired) begin
                        err_code  <= ERR_LOCK;
                        state_reg <= ST_FIN;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                ST_FIN: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
